// File: rtl/cop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cop_pkg
// Description : Opcodes, instruction field positions and issue FSM states
//               shared by the coprocessor issue block.
// Revision    : 1.0 - initial release
// ============================================================================
package cop_pkg;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_ADD = 6'b110000;
    localparam logic [5:0] OP_SUB = 6'b110001;
    localparam logic [5:0] OP_MUL = 6'b110010;
    localparam logic [5:0] OP_DIV = 6'b110011;
    localparam logic [5:0] OP_CMP = 6'b110100;
    localparam logic [5:0] OP_REV = 6'b110101;
    localparam logic [5:0] OP_RND = 6'b110110;
    localparam logic [5:0] OP_LW  = 6'b110111;
    localparam logic [5:0] OP_SW  = 6'b111000;

    localparam int c_OPC_HI = 31;
    localparam int c_OPC_LO = 26;
    localparam int c_IN1_HI = 25;
    localparam int c_IN1_LO = 21;
    localparam int c_IN2_HI = 20;
    localparam int c_IN2_LO = 16;
    localparam int c_DST_HI = 15;
    localparam int c_DST_LO = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_SWCAP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cop_lat_lut.sv
`default_nettype none
// ============================================================================
// Module      : cop_lat_lut
// Description : Combinational opcode decode to {legal, busy latency}.
// Revision    : 1.0 - initial release
// ============================================================================
module cop_lat_lut
    import cop_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic [5:0] opcode,
    output logic       legal,
    output logic [3:0] latency
);

    always_comb begin
        legal   = 1'b1;
        latency = 4'd1;
        case (opcode)
            OP_ADD, OP_SUB, OP_CMP, OP_RND, OP_LW: latency = 4'd1;
            OP_MUL:         latency = 4'(MUL_LAT);
            OP_DIV, OP_REV: latency = 4'(DIV_LAT);
            OP_SW:          latency = 4'd2;
            default: begin
                legal   = 1'b0;
                latency = 4'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cop_issue.sv
`default_nettype none
// ============================================================================
// Module      : cop_issue
// Description : Issues decoded instructions to a coprocessor, tracks busy
//               latency and returns sw results. Optional performance
//               counters are enabled by COP_ISSUE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cop_issue
    import cop_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic [31:0] load_data,
    output logic [5:0]  cop_opcode,
    output logic [4:0]  cop_addr_in1,
    output logic [4:0]  cop_addr_in2,
    output logic [4:0]  cop_addr_dest,
    output logic [31:0] cop_indata,
    input  logic [31:0] cop_outdata,
    output logic        store_valid,
    output logic [31:0] store_data,
    output logic        illegal
`ifdef COP_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0] issue_cnt,
    output logic [31:0] stall_cnt
`endif
);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [5:0] w_opcode;
    logic       w_legal;
    logic [3:0] w_lat;
    logic       w_accept;
    logic       w_unused_bits;

    assign w_opcode      = instr[c_OPC_HI:c_OPC_LO];
    assign w_unused_bits = ^instr[c_DST_LO-1:0];

    cop_lat_lut #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_lat_lut (
        .opcode  (w_opcode),
        .legal   (w_legal),
        .latency (w_lat)
    );

    assign instr_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept    = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 4'd0;
            cop_opcode    <= OP_NOP;
            cop_addr_in1  <= 5'd0;
            cop_addr_in2  <= 5'd0;
            cop_addr_dest <= 5'd0;
            cop_indata    <= 32'd0;
            store_data    <= 32'd0;
            store_valid   <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            cop_opcode  <= OP_NOP;
            store_valid <= 1'b0;
            illegal     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            cop_opcode    <= w_opcode;
                            cop_addr_in1  <= instr[c_IN1_HI:c_IN1_LO];
                            cop_addr_in2  <= instr[c_IN2_HI:c_IN2_LO];
                            cop_addr_dest <= instr[c_DST_HI:c_DST_LO];
                            cop_indata    <= load_data;
                            // Single-cycle ops stay in IDLE so accepts can run back to back
                            if (w_opcode == OP_SW) begin
                                r_state <= ST_SWCAP;
                            end else if (w_lat > 4'd1) begin
                                r_state <= ST_BUSY;
                                r_cnt   <= w_lat - 4'd1;
                            end
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_SWCAP: begin
                    store_data  <= cop_outdata;
                    store_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef COP_ISSUE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (w_accept && w_legal) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if (instr_valid && !instr_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cop_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_cop_issue
// Description : Self-checking bench for cop_issue: directed scenarios with
//               literal expectations, then randomized traffic vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cop_issue;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] load_data;
    logic [5:0]  cop_opcode;
    logic [4:0]  cop_addr_in1;
    logic [4:0]  cop_addr_in2;
    logic [4:0]  cop_addr_dest;
    logic [31:0] cop_indata;
    logic [31:0] cop_outdata;
    logic        store_valid;
    logic [31:0] store_data;
    logic        illegal;
`ifdef COP_ISSUE_PERF_CNT_EN
    logic [31:0] issue_cnt;
    logic [31:0] stall_cnt;
`endif

    cop_issue #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .load_data     (load_data),
        .cop_opcode    (cop_opcode),
        .cop_addr_in1  (cop_addr_in1),
        .cop_addr_in2  (cop_addr_in2),
        .cop_addr_dest (cop_addr_dest),
        .cop_indata    (cop_indata),
        .cop_outdata   (cop_outdata),
        .store_valid   (store_valid),
        .store_data    (store_data),
        .illegal       (illegal)
`ifdef COP_ISSUE_PERF_CNT_EN
        ,
        .issue_cnt     (issue_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] d);
        return {op, a, b, d, 11'h0};
    endfunction

    // Extra cycles with instr_ready low after an accepted legal opcode
    function automatic int extra_busy(input logic [5:0] op);
        int lat;
        if (op == 6'b111000) return 1;
        if (op == 6'b110010) lat = MUL_LAT;
        else if (op == 6'b110011 || op == 6'b110101) lat = DIV_LAT;
        else lat = 1;
        return (lat > 1) ? lat : 0;
    endfunction

    // Reference model: timeline of edges, the first edge at which a new
    // instruction may be accepted, and the edge at which sw data is captured.
    int          edge_n    = 0;
    int          next_free = 0;
    int          store_at  = -1;
    bit          chk_en    = 1'b0;
    logic [5:0]  e_op;
    logic [4:0]  e_in1, e_in2, e_dst;
    logic [31:0] e_indata, e_sd;
    logic        e_sv, e_ill;
    logic [31:0] m_issue, m_stall;

    always @(posedge clk) begin
        logic [5:0] op;
        edge_n++;
        e_op  = 6'd0;
        e_sv  = 1'b0;
        e_ill = 1'b0;
        if (rst) begin
            chk_en    = 1'b1;
            e_in1     = 5'd0;
            e_in2     = 5'd0;
            e_dst     = 5'd0;
            e_indata  = 32'd0;
            e_sd      = 32'd0;
            next_free = edge_n + 1;
            store_at  = -1;
            m_issue   = 32'd0;
            m_stall   = 32'd0;
        end else begin
            if (store_at == edge_n) begin
                e_sd = cop_outdata;
                e_sv = 1'b1;
            end
            if (instr_valid && edge_n < next_free) m_stall = m_stall + 32'd1;
            if (instr_valid && edge_n >= next_free) begin
                op = instr[31:26];
                if (op >= 6'b110000 && op <= 6'b111000) begin
                    e_op      = op;
                    e_in1     = instr[25:21];
                    e_in2     = instr[20:16];
                    e_dst     = instr[15:11];
                    e_indata  = load_data;
                    m_issue   = m_issue + 32'd1;
                    next_free = edge_n + 1 + extra_busy(op);
                    if (op == 6'b111000) store_at = edge_n + 1;
                end else begin
                    e_ill = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_opcode", 32'(cop_opcode), 32'(e_op));
            chk("m_in1", 32'(cop_addr_in1), 32'(e_in1));
            chk("m_in2", 32'(cop_addr_in2), 32'(e_in2));
            chk("m_dest", 32'(cop_addr_dest), 32'(e_dst));
            chk("m_indata", cop_indata, e_indata);
            chk("m_store_valid", 32'(store_valid), 32'(e_sv));
            chk("m_store_data", store_data, e_sd);
            chk("m_illegal", 32'(illegal), 32'(e_ill));
            chk("m_ready", 32'(instr_ready), 32'(!rst && (edge_n + 1 >= next_free)));
`ifdef COP_ISSUE_PERF_CNT_EN
            chk("m_issue_cnt", issue_cnt, m_issue);
            chk("m_stall_cnt", stall_cnt, m_stall);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  op;
        rst         = 1'b1;
        instr_valid = 1'b1;
        instr       = mk(6'b110000, 5'd1, 5'd2, 5'd3);
        load_data   = 32'hDEADBEEF;
        cop_outdata = 32'h0;

        // Reset held two cycles with a pending instruction
        cyc();
        cyc();
        chk("rst_opcode", 32'(cop_opcode), 32'h0);
        chk("rst_store_valid", 32'(store_valid), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_indata", cop_indata, 32'h0);
        chk("rst_ready_low", 32'(instr_ready), 32'h0);
        rst = 1'b0;
        instr_valid = 1'b0;
        cyc();
        chk("ready_after_rst", 32'(instr_ready), 32'h1);

        // Back-to-back single-cycle ops
        instr_valid = 1'b1;
        instr = mk(6'b110000, 5'd1, 5'd2, 5'd3);
        cyc();
        chk("add_opcode", 32'(cop_opcode), 32'h30);
        chk("add_in1", 32'(cop_addr_in1), 32'd1);
        chk("add_in2", 32'(cop_addr_in2), 32'd2);
        chk("add_dest", 32'(cop_addr_dest), 32'd3);
        chk("add_ready", 32'(instr_ready), 32'h1);
        instr = mk(6'b110001, 5'd4, 5'd5, 5'd6);
        cyc();
        chk("sub_opcode", 32'(cop_opcode), 32'h31);
        chk("sub_ready", 32'(instr_ready), 32'h1);
        instr_valid = 1'b0;
        cyc();
        chk("nop_after_sub", 32'(cop_opcode), 32'h0);

        // div then a held mul
        instr_valid = 1'b1;
        instr = mk(6'b110011, 5'd7, 5'd8, 5'd9);
        cyc();
        chk("div_opcode", 32'(cop_opcode), 32'h33);
        chk("div_busy1", 32'(instr_ready), 32'h0);
        instr = mk(6'b110010, 5'd1, 5'd1, 5'd1);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            chk("div_busy", 32'(instr_ready), 32'h0);
            chk("div_no_issue", 32'(cop_opcode), 32'h0);
        end
        cyc();
        chk("div_ready5", 32'(instr_ready), 32'h1);
        cyc();
        chk("mul_opcode", 32'(cop_opcode), 32'h32);
        instr_valid = 1'b0;
        cyc();
        chk("mul_busy", 32'(instr_ready), 32'h0);
        cyc();
        chk("mul_done", 32'(instr_ready), 32'h1);

        // lw
        instr_valid = 1'b1;
        instr = mk(6'b110111, 5'd5, 5'd0, 5'd0);
        load_data = 32'h3F800000;
        cyc();
        chk("lw_opcode", 32'(cop_opcode), 32'h37);
        chk("lw_indata", cop_indata, 32'h3F800000);
        chk("lw_in1", 32'(cop_addr_in1), 32'd5);
        instr_valid = 1'b0;
        load_data = 32'h0;
        cyc();
        chk("lw_opcode_gone", 32'(cop_opcode), 32'h0);
        chk("lw_indata_hold", cop_indata, 32'h3F800000);

        // sw
        instr_valid = 1'b1;
        instr = mk(6'b111000, 5'd5, 5'd0, 5'd0);
        cop_outdata = 32'h40490FDB;
        cyc();
        chk("sw_opcode", 32'(cop_opcode), 32'h38);
        chk("sw_sv_early", 32'(store_valid), 32'h0);
        chk("sw_ready_low", 32'(instr_ready), 32'h0);
        instr_valid = 1'b0;
        cyc();
        chk("sw_store_valid", 32'(store_valid), 32'h1);
        chk("sw_store_data", store_data, 32'h40490FDB);
        cop_outdata = 32'h0;
        cyc();
        chk("sw_sv_once", 32'(store_valid), 32'h0);
        chk("sw_data_hold", store_data, 32'h40490FDB);

        // Illegal opcode
        instr_valid = 1'b1;
        instr = mk(6'b000111, 5'd1, 5'd2, 5'd3);
        cyc();
        chk("ill_pulse", 32'(illegal), 32'h1);
        chk("ill_opcode", 32'(cop_opcode), 32'h0);
        chk("ill_ready", 32'(instr_ready), 32'h1);
        instr_valid = 1'b0;
        cyc();
        chk("ill_once", 32'(illegal), 32'h0);

        // Reset while in SWCAP aborts the store
        instr_valid = 1'b1;
        instr = mk(6'b111000, 5'd2, 5'd0, 5'd0);
        cop_outdata = 32'h12345678;
        cyc();
        rst = 1'b1;
        instr_valid = 1'b0;
        cyc();
        chk("abort_sv", 32'(store_valid), 32'h0);
        chk("abort_sd", store_data, 32'h0);
        rst = 1'b0;
        cyc();
        chk("abort_sv2", 32'(store_valid), 32'h0);
        chk("abort_ready", 32'(instr_ready), 32'h1);

        // Randomized traffic checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            instr_valid = ($urandom_range(0, 99) < 70);
            r = $urandom();
            if ($urandom_range(0, 99) < 85) op = 6'(6'b110000 + $urandom_range(0, 8));
            else op = 6'($urandom_range(0, 63));
            instr = {op, r[25:0]};
            load_data = $urandom();
            cop_outdata = $urandom();
            cyc();
        end
        rst = 1'b0;
        instr_valid = 1'b0;
        repeat (20) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
